// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Payload data is carried at DATA_W_MAX bits; the top zero-extends and truncates to its DATA_W.
package wb_arb_pkg;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned DATA_W_MAX = 64;
  localparam logic [REG_W-1:0] XZR   = 5'd31;

  typedef struct packed {
    logic [REG_W-1:0]      rd;
    logic [DATA_W_MAX-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    IDLE,
    PIPE,
    DRAIN,
    FORCE
  } grant_e;

endpackage

// File: rtl/wb_arb_fifo.sv
// Side-unit result FIFO: occupancy-based full/empty, pointers wrap modulo DEPTH.
// Exposes per-entry valid/target-register views for the RAW scoreboard.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              push,
  input  wb_req_t                           push_req,
  input  logic                              pop,
  output wb_req_t                           head,
  output logic [$clog2(DEPTH+1)-1:0]        q_count,
  output logic [DEPTH-1:0]                  ent_valid,
  output logic [DEPTH-1:0][REG_W-1:0]       ent_rd
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers and occupancy; DEPTH is a power of two so natural overflow wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + CNT_W'(1);
        2'b01:   q_count <= q_count - CNT_W'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  assign head = mem[rd_ptr];

  // An entry is live when its distance from the read pointer is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign ent_valid[g] = CNT_W'(PTR_W'(PTR_W'(g) - rd_ptr)) < q_count;
    assign ent_rd[g]    = mem[g].rd;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between WB and the side-unit FIFO,
// with starvation-forced drains. Optional RAW scoreboard under WB_ARB_SCOREBOARD_EN.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wb_we,
  input  logic [4:0]                 wb_reg,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       mc_valid,
  output logic                       mc_ready,
  input  logic [4:0]                 mc_reg,
  input  logic [DATA_W-1:0]          mc_data,
  output logic                       stall_req,
  output logic                       rf_we,
  output logic [4:0]                 rf_reg,
  output logic [DATA_W-1:0]          rf_data,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  input  logic [4:0]                 query_reg,
  output logic                       query_hit
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  wb_req_t                  push_req;
  wb_req_t                  head;
  logic                     push;
  logic                     pop;
  logic                     wb_valid;
  logic                     fifo_nonempty;
  logic [WAIT_W-1:0]        wait_cnt;
  grant_e                   grant;
  logic [DEPTH-1:0]         ent_valid;
  logic [DEPTH-1:0][REG_W-1:0] ent_rd;

  assign mc_ready      = q_count < CNT_W'(DEPTH);
  assign fifo_nonempty = q_count != '0;
  assign stall_req     = (wait_cnt == WAIT_W'(MAX_WAIT)) && fifo_nonempty;
  assign wb_valid      = wb_we && (wb_reg != XZR);

  // XZR results are handshaken but never stored.
  assign push = mc_valid && mc_ready && (mc_reg != XZR);
  assign pop  = (grant == FORCE) || (grant == DRAIN);

  always_comb begin
    push_req      = '0;
    push_req.rd   = mc_reg;
    push_req.data = DATA_W_MAX'(mc_data);
  end

  always_comb begin
    grant = IDLE;
    if (stall_req)          grant = FORCE;
    else if (wb_valid)      grant = PIPE;
    else if (fifo_nonempty) grant = DRAIN;
  end

  wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_req  (push_req),
    .pop       (pop),
    .head      (head),
    .q_count   (q_count),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  // Write-port registers and head aging; IDLE keeps the last address/data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we    <= 1'b0;
      rf_reg   <= '0;
      rf_data  <= '0;
      wait_cnt <= '0;
    end else begin
      rf_we <= (grant != IDLE);
      case (grant)
        PIPE: begin
          rf_reg  <= wb_reg;
          rf_data <= wb_data;
          if (fifo_nonempty && (wait_cnt != WAIT_W'(MAX_WAIT)))
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        DRAIN, FORCE: begin
          rf_reg   <= head.rd;
          rf_data  <= DATA_W'(head.data);
          wait_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef WB_ARB_SCOREBOARD_EN
  logic [DEPTH-1:0] ent_hit;

  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
    assign ent_hit[g] = ent_valid[g] && (ent_rd[g] == query_reg);
  end

  assign query_hit = (query_reg != XZR) &&
                     ((|ent_hit) || (rf_we && (rf_reg == query_reg)));
`else
  logic unused_sb;
  assign unused_sb = ^{query_reg, ent_valid, ent_rd};
  assign query_hit = 1'b0;
`endif

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the pipeline writeback stage and a long-latency side unit (multiply/divide result path).
- Pipeline WB normally wins. Side-unit results queue in a small FIFO.
- A starvation counter forces a one-cycle pipeline stall so a queued result can drain.
- Sits between the WB stage/side unit and the register file write inputs.

Parameters:
- DATA_W, 64, register data width
- DEPTH, 2, side-unit FIFO entries (power of 2, >=2)
- MAX_WAIT, 4, cycles a FIFO head may be blocked before stall_req asserts

Ports:
- clk  in  1  single clock, rising-edge
- reset_n  in  1  asynchronous, active-low reset
- wb_we  in  1  WB stage write request (RegWrite_WB)
- wb_reg  in  5  WB target register
- wb_data  in  DATA_W  WB write data
- mc_valid  in  1  side unit result valid
- mc_ready  out  1  FIFO can accept
- mc_reg  in  5  side unit target register
- mc_data  in  DATA_W  side unit result
- stall_req  out  1  pipeline must hold WB contents this cycle
- rf_we  out  1  register-file write enable (registered)
- rf_reg  out  5  register-file write address (registered)
- rf_data  out  DATA_W  register-file write data (registered)
- q_count  out  $clog2(DEPTH+1)  FIFO occupancy
- query_reg  in  5  decode-stage source register to check
- query_hit  out  1  query_reg has a pending side-unit write

Behaviour:
- Reset (async, reset_n low): FIFO empty, q_count=0, wait_cnt=0, rf_we=0, rf_reg=0, rf_data=0, stall_req=0, mc_ready=1. Reset mid-operation discards all queued entries and any in-flight grant.
- Push:
  - Occurs when mc_valid && mc_ready.
  - mc_ready = (q_count < DEPTH), computed from the current count only. No same-cycle pass-through when full, even if a pop occurs.
  - mc_reg==31 (XZR) is accepted and discarded; it never enters the FIFO.
- Grant, evaluated each cycle; result is registered onto rf_* at the next rising edge (latency 1):
  - FORCE (stall_req=1): FIFO head is granted and popped. wb_* is ignored; the pipeline replays it next cycle.
  - PIPE (wb_we=1, wb_reg!=31, stall_req=0): WB is granted. If the FIFO is nonempty, wait_cnt increments (saturating at MAX_WAIT).
  - DRAIN (no valid WB request, FIFO nonempty): head is granted and popped, wait_cnt=0.
  - IDLE: rf_we=0 next cycle. rf_reg and rf_data hold their previous values.
- wb_reg==31 with wb_we=1 counts as no request (rf_we stays 0). It does not age the FIFO head.
- stall_req = (wait_cnt==MAX_WAIT) && (q_count!=0). It is combinational from registered state, so it is high for exactly one cycle per forced drain. wait_cnt clears on every pop.
- Simultaneous push and pop: q_count unchanged, the new entry goes to the tail, and FIFO order is preserved.
- Pointer wrap: read/write pointers wrap modulo DEPTH. Full/empty are derived from q_count, never from pointer equality.
- No two writes are ever issued in one cycle. Every non-XZR request is eventually written; nothing is dropped except on reset.

Optional Feature:
- Macro: WB_ARB_SCOREBOARD_EN.
- Defined: query_hit=1 if query_reg!=31 and query_reg matches any valid FIFO entry, or matches rf_reg while rf_we=1. Decode uses this to stall on a RAW hazard against a queued side-unit result.
- Undefined: query_hit is tied 0, query_reg is unused, and no comparators are synthesized.

Decomposition:
- Package wb_arb_pkg holds:
  - REG_W=5, XZR=5'd31
  - typedef wb_req_t (reg[4:0], data[DATA_W-1:0])
  - typedef grant_e {IDLE, PIPE, DRAIN, FORCE}
- Sub-module wb_arb_fifo: DEPTH-entry wb_req_t FIFO with push/pop, head, q_count, and per-entry valid/reg outputs for the scoreboard.
- Grant, aging and output registers stay in the top module.

Test Plan:
- Reset: hold reset_n=0 with mc_valid=1 -> rf_we=0, q_count=0, stall_req=0. Release reset -> mc_ready=1.
- Idle drain: wb_we=0; push mc_reg=5, mc_data=42069 -> next cycle q_count=1. Following edge: rf_we=1, rf_reg=5, rf_data=42069, q_count=0.
- Starvation: push mc_reg=7, data=69420; hold wb_we=1, wb_reg=3 every cycle -> rf_reg=3 for 4 cycles, then stall_req=1 for one cycle. Next edge: rf_reg=7, rf_data=69420.
- Full: DEPTH=2, three back-to-back pushes while WB is busy -> mc_ready=0 after the second push. The third is held by the side unit, accepted once a pop occurs, and order is preserved.
- XZR: wb_we=1, wb_reg=31 and mc_reg=31 pushed -> rf_we stays 0, q_count stays 0.
- Scoreboard (WB_ARB_SCOREBOARD_EN): queue reg 9, query_reg=9 -> query_hit=1. After its write retires, query_hit=0. With the macro undefined, query_hit=0 always.
